// File: rtl/dragon_ram_arbiter_if.sv
// Request/response bus between the DragonRAM masters and the arbiter.
// Each master's address and data occupy their own slice of the packed vectors.
interface dragon_ram_arbiter_if #(
    parameter int AddressWidth = 10,
    parameter int DataWidth    = 36,
    parameter int Requesters   = 3
);
    logic [Requesters-1:0]              req_vld;
    logic [Requesters-1:0]              req_write;
    logic [Requesters*AddressWidth-1:0] req_addr;
    logic [Requesters*DataWidth-1:0]    req_dat;
    logic [Requesters-1:0]              req_rdy;
    logic [Requesters-1:0]              rsp_vld;
    logic [DataWidth-1:0]               rsp_dat;

    modport master (
        output req_vld, req_write, req_addr, req_dat,
        input  req_rdy, rsp_vld, rsp_dat
    );

    modport slave (
        input  req_vld, req_write, req_addr, req_dat,
        output req_rdy, rsp_vld, rsp_dat
    );
endinterface

// File: rtl/dragon_ram_arbiter.sv
// Serialises Requesters masters onto one DragonRAM port, round-robin unless DRAGON_RAM_ARB_FIXED_PRIORITY_EN.
// Write response 2 cycles after accept, read 3; masters hold req_vld while req_rdy is low (only raised in IDLE).
module dragon_ram_arbiter #(
    parameter int AddressWidth = 10,
    parameter int DataWidth    = 36,
    parameter int Requesters   = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    dragon_ram_arbiter_if.slave     bus_if,
    output logic                    ram_we_o,
    output logic [AddressWidth-1:0] ram_addr_o,
    output logic [DataWidth-1:0]    ram_wdata_o,
    input  logic [DataWidth-1:0]    ram_rdata_i
);
    localparam int IdxW = (Requesters > 2) ? 2 : 1;

    if (Requesters < 2 || Requesters > 4) begin : g_bad_requesters
        $error("dragon_ram_arbiter: Requesters must be 2..4");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_READ} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, win_idx;
    logic                    wr_q;
    logic                    any_vld;
    logic                    ram_we_q;
    logic [AddressWidth-1:0] ram_addr_q;
    logic [DataWidth-1:0]    ram_wdata_q;
    logic [Requesters-1:0]   rsp_vld_q;
    logic [DataWidth-1:0]    rsp_dat_q;
    logic [Requesters-1:0]   idx_onehot;
`ifndef DRAGON_RAM_ARB_FIXED_PRIORITY_EN
    logic [IdxW-1:0]         last_q;
`endif

    assign any_vld    = |bus_if.req_vld;
    assign idx_onehot = {{(Requesters-1){1'b0}}, 1'b1} << idx_q;

    // Later assignments win, so iterate from the back of the search order.
    always_comb begin : win_sel
        logic [IdxW-1:0] cand;
        cand    = '0;
        win_idx = '0;
`ifdef DRAGON_RAM_ARB_FIXED_PRIORITY_EN
        for (int i = Requesters - 1; i >= 0; i--) begin
            cand = IdxW'(i);
            if (bus_if.req_vld[cand]) win_idx = cand;
        end
`else
        for (int k = Requesters; k >= 1; k--) begin
            cand = IdxW'((int'(last_q) + k) % Requesters);
            if (bus_if.req_vld[cand]) win_idx = cand;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_vld) state_d = ST_ISSUE;
            ST_ISSUE: state_d = wr_q ? ST_IDLE : ST_READ;
            ST_READ:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_if.req_rdy = '0;
        if (state_q == ST_IDLE && any_vld) bus_if.req_rdy[win_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q       <= '0;
            wr_q        <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rsp_vld_q   <= '0;
            rsp_dat_q   <= '0;
`ifndef DRAGON_RAM_ARB_FIXED_PRIORITY_EN
            last_q      <= IdxW'(Requesters - 1);
`endif
        end else begin
            rsp_vld_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any_vld) begin
                        ram_addr_q  <= bus_if.req_addr[32'(win_idx)*AddressWidth +: AddressWidth];
                        ram_wdata_q <= bus_if.req_dat[32'(win_idx)*DataWidth +: DataWidth];
                        ram_we_q    <= bus_if.req_write[win_idx];
                        wr_q        <= bus_if.req_write[win_idx];
                        idx_q       <= win_idx;
`ifndef DRAGON_RAM_ARB_FIXED_PRIORITY_EN
                        last_q      <= win_idx;
`endif
                    end
                end
                ST_ISSUE: begin
                    ram_we_q <= 1'b0;
                    if (wr_q) rsp_vld_q <= idx_onehot;
                end
                ST_READ: begin
                    rsp_dat_q <= ram_rdata_i;
                    rsp_vld_q <= idx_onehot;
                end
                default: ;
            endcase
        end
    end

    assign ram_we_o       = ram_we_q;
    assign ram_addr_o     = ram_addr_q;
    assign ram_wdata_o    = ram_wdata_q;
    assign bus_if.rsp_vld = rsp_vld_q;
    assign bus_if.rsp_dat = rsp_dat_q;
endmodule
